// File: rtl/draw_issue.sv
// draw_issue: CPU-side initiator for DXYN.
// It latches the sprite operands, waits for the draw engine to be free, and
// pulses draw_en once. It then collects the collision flag while the engine
// runs, writes VF, and pulses done.
// Optional macro DRAW_VSYNC_WAIT_EN: each launch also waits for a vs_i falling
// edge, which limits the issuer to one draw per frame.
module draw_issue #(
  parameter int unsigned REG_WIDTH = 8,
  parameter int unsigned I_WIDTH   = 16,
  parameter int unsigned X_BITS    = 6,
  parameter int unsigned Y_BITS    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     ready,
  input  logic [REG_WIDTH-1:0]     vx,
  input  logic [REG_WIDTH-1:0]     vy,
  input  logic [3:0]               n,
  input  logic [I_WIDTH-1:0]       i_addr,
  output logic                     draw_en,
  output logic [I_WIDTH-1:0]       draw_I,
  output logic [Y_BITS+X_BITS-1:0] draw_start_pix,
  output logic [3:0]               draw_nibbles,
  input  logic                     draw_busy,
  input  logic                     draw_col,
  input  logic                     vs_i,
  output logic                     vf_we,
  output logic [REG_WIDTH-1:0]     vf_d,
  output logic                     done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FREE,
    S_LAUNCH,
    S_RUN,
    S_WRITE_VF
  } state_t;

  state_t state_q, state_d;
  logic   col_acc_q, col_acc_d;
  logic   load;
  logic   launch_ok;

  // Upper operand bits are dropped: coordinates wrap by truncation
  logic unused_bits;

`ifdef DRAW_VSYNC_WAIT_EN
  logic vs_q;
  logic vs_seen_q, vs_seen_d;
  logic vs_fall;

  assign vs_fall     = vs_q & ~vs_i;
  assign launch_ok   = vs_seen_q & ~draw_busy;
  assign unused_bits = ^{vx[REG_WIDTH-1:X_BITS], vy[REG_WIDTH-1:Y_BITS]};

  // Register vsync and remember a falling edge seen while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      vs_seen_q <= 1'b0;
    end else begin
      vs_q      <= vs_i;
      vs_seen_q <= vs_seen_d;
    end
  end

  // Clear the latched edge on each accepted start; set it on a fall in WAIT_FREE
  always_comb begin
    vs_seen_d = vs_seen_q;
    if (state_q == S_IDLE && start) begin
      vs_seen_d = 1'b0;
    end else if (state_q == S_WAIT_FREE && vs_fall) begin
      vs_seen_d = 1'b1;
    end
  end
`else
  assign launch_ok   = ~draw_busy;
  assign unused_bits = ^{vs_i, vx[REG_WIDTH-1:X_BITS], vy[REG_WIDTH-1:Y_BITS]};
`endif

  // State register and collision accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      col_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_acc_q <= col_acc_d;
    end
  end

  // Next-state logic; never launch into a busy engine
  always_comb begin
    state_d   = state_q;
    col_acc_d = col_acc_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          col_acc_d = 1'b0;
          state_d   = (n != 4'd0) ? S_WAIT_FREE : S_WRITE_VF;
        end
      end
      S_WAIT_FREE: begin
        if (launch_ok) begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        col_acc_d = col_acc_q | draw_col;
        if (!draw_busy) begin
          state_d = S_WRITE_VF;
        end
      end
      S_WRITE_VF: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered Moore outputs, decoded from the next state so they line up with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready   <= 1'b1;
      draw_en <= 1'b0;
      vf_we   <= 1'b0;
      done    <= 1'b0;
      vf_d    <= '0;
    end else begin
      ready   <= (state_d == S_IDLE);
      draw_en <= (state_d == S_LAUNCH);
      vf_we   <= (state_d == S_WRITE_VF);
      done    <= (state_d == S_WRITE_VF);
      vf_d    <= (state_d == S_WRITE_VF) ? {{(REG_WIDTH-1){1'b0}}, col_acc_d} : '0;
    end
  end

  // Operands are captured at start and held until the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw_I         <= '0;
      draw_start_pix <= '0;
      draw_nibbles   <= '0;
    end else if (load) begin
      draw_I         <= i_addr;
      draw_start_pix <= {vy[Y_BITS-1:0], vx[X_BITS-1:0]};
      draw_nibbles   <= n;
    end
  end

endmodule

// File: tb/tb_draw_issue.sv
// Directed bench for draw_issue, with a small behavioural draw engine model.
module tb_draw_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic [7:0]  vx, vy;
  logic [3:0]  n;
  logic [15:0] i_addr;
  logic        draw_en;
  logic [15:0] draw_I;
  logic [10:0] draw_start_pix;
  logic [3:0]  draw_nibbles;
  logic        draw_busy;
  logic        draw_col;
  logic        vs_i;
  logic        vf_we;
  logic [7:0]  vf_d;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Engine model: busy during the enable cycle, then for eng_len more cycles
  int   eng_len = 4;
  int   eng_cnt = 0;
  logic ext_busy;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (draw_en) eng_cnt <= eng_len;
    else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
  end

  assign draw_busy = ext_busy | draw_en | (eng_cnt != 0);

  draw_issue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .ready          (ready),
    .vx             (vx),
    .vy             (vy),
    .n              (n),
    .i_addr         (i_addr),
    .draw_en        (draw_en),
    .draw_I         (draw_I),
    .draw_start_pix (draw_start_pix),
    .draw_nibbles   (draw_nibbles),
    .draw_busy      (draw_busy),
    .draw_col       (draw_col),
    .vs_i           (vs_i),
    .vf_we          (vf_we),
    .vf_d           (vf_d),
    .done           (done)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Start held during cycle T; returns at the sample point of cycle T+1
  task automatic pulse_start(input logic [7:0] x, input logic [7:0] y,
                             input logic [3:0] nn, input logic [15:0] ii);
    vx = x; vy = y; n = nn; i_addr = ii;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; vx = '0; vy = '0; n = '0; i_addr = '0;
    ext_busy = 1'b0; draw_col = 1'b0; vs_i = 1'b0;
    #12;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++;
    if ({draw_en, vf_we, done} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000", {draw_en, vf_we, done});
    end
    checks++;
    if ({draw_I, draw_start_pix, draw_nibbles, vf_d} !== 39'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {draw_I, draw_start_pix, draw_nibbles, vf_d});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_basic;
    eng_len = 4;
    pulse_start(8'h45, 8'h23, 4'd5, 16'h0300);
    checks++;
    if ({ready, draw_en} !== 2'b00) begin errors++; $display("FAIL basic_t1_ctl: got %b expected 00", {ready, draw_en}); end
    checks++;
    if (draw_start_pix !== 11'h0C5) begin errors++; $display("FAIL basic_pix: got %h expected 0c5", draw_start_pix); end
    checks++;
    if (draw_nibbles !== 4'd5) begin errors++; $display("FAIL basic_nib: got %0d expected 5", draw_nibbles); end
    checks++;
    if (draw_I !== 16'h0300) begin errors++; $display("FAIL basic_I: got %h expected 0300", draw_I); end
    step;
    checks++;
    if (draw_en !== 1'b1) begin errors++; $display("FAIL basic_en_t2: got %b expected 1", draw_en); end
    for (int k = 3; k <= 7; k++) begin
      step;
      checks++;
      if ({draw_en, done} !== 2'b00) begin
        errors++; $display("FAIL basic_run_t%0d: got %b expected 00", k, {draw_en, done});
      end
    end
    step;
    checks++;
    if ({vf_we, done, ready} !== 3'b110) begin errors++; $display("FAIL basic_done: got %b expected 110", {vf_we, done, ready}); end
    checks++;
    if (vf_d !== 8'h00) begin errors++; $display("FAIL basic_vf: got %h expected 00", vf_d); end
    checks++;
    if (draw_start_pix !== 11'h0C5) begin errors++; $display("FAIL basic_pix_hold: got %h expected 0c5", draw_start_pix); end
    step;
    checks++;
    if ({ready, done, vf_we} !== 3'b100) begin errors++; $display("FAIL basic_idle: got %b expected 100", {ready, done, vf_we}); end
  endtask

  // Collision pulse at cycle T+col_at; RUN spans T+3..T+7 with busy falling at T+7
  task automatic test_collision(input int col_at);
    eng_len = 4;
    pulse_start(8'h45, 8'h23, 4'd5, 16'h0300);
    for (int k = 1; k < 8; k++) begin
      draw_col = (k == col_at);
      step;
    end
    draw_col = 1'b0;
    checks++;
    if ({done, vf_we} !== 2'b11) begin errors++; $display("FAIL col%0d_done: got %b expected 11", col_at, {done, vf_we}); end
    checks++;
    if (vf_d !== 8'h01) begin errors++; $display("FAIL col%0d_vf: got %h expected 01", col_at, vf_d); end
    step;
  endtask

  task automatic test_busy_hold;
    int got;
    eng_len = 2;
    ext_busy = 1'b1;
    pulse_start(8'h10, 8'h02, 4'd3, 16'h0200);
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if ({ready, draw_en} !== 2'b00) begin
        errors++; $display("FAIL busy_wait_t%0d: got %b expected 00", k, {ready, draw_en});
      end
      if (k == 3) begin vx = 8'h3F; n = 4'd0; end
      start = (k == 3);
      if (k == 10) ext_busy = 1'b0;
      step;
    end
    start = 1'b0;
    checks++;
    if (draw_en !== 1'b1) begin errors++; $display("FAIL busy_launch: got %b expected 1", draw_en); end
    checks++;
    if ({draw_start_pix, draw_nibbles} !== {11'h090, 4'd3}) begin
      errors++; $display("FAIL busy_ignore_start: got %h expected %h", {draw_start_pix, draw_nibbles}, {11'h090, 4'd3});
    end
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      step;
      if (done) got = 1;
    end
    checks++;
    if (got != 1) begin errors++; $display("FAIL busy_done_timeout: got %0d expected 1", got); end
    step;
  endtask

  task automatic test_n_zero;
    draw_col = 1'b1;
    pulse_start(8'h45, 8'h23, 4'd0, 16'h0123);
    draw_col = 1'b0;
    checks++;
    if ({vf_we, done, draw_en} !== 3'b110) begin errors++; $display("FAIL nzero_t1: got %b expected 110", {vf_we, done, draw_en}); end
    checks++;
    if (vf_d !== 8'h00) begin errors++; $display("FAIL nzero_vf: got %h expected 00", vf_d); end
    for (int k = 2; k <= 4; k++) begin
      step;
      checks++;
      if ({ready, draw_en, done} !== 3'b100) begin
        errors++; $display("FAIL nzero_idle_t%0d: got %b expected 100", k, {ready, draw_en, done});
      end
    end
  endtask

  task automatic test_reset_mid_run;
    int got;
    int guard;
    eng_len = 20;
    pulse_start(8'h01, 8'h02, 4'd4, 16'h0400);
    step; step; step;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, draw_en, vf_we, done} !== 4'b1000) begin
      errors++; $display("FAIL rst_mid_ctl: got %b expected 1000", {ready, draw_en, vf_we, done});
    end
    checks++;
    if ({draw_I, draw_start_pix, draw_nibbles, vf_d} !== 39'd0) begin
      errors++; $display("FAIL rst_mid_data: got %h expected 0", {draw_I, draw_start_pix, draw_nibbles, vf_d});
    end
    #2;
    rst_n = 1'b1;
    step;
    eng_len = 2;
    pulse_start(8'h05, 8'h06, 4'd2, 16'h0500);
    checks++;
    if (draw_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_engine_busy: got %b expected 1", draw_busy); end
    guard = 0;
    while (draw_busy && guard < 60) begin
      checks++;
      if (draw_en !== 1'b0) begin errors++; $display("FAIL rst_mid_en_while_busy: got %b expected 0", draw_en); end
      step;
      guard++;
    end
    checks++;
    if (draw_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_timeout: got %b expected 0", draw_busy); end
    step;
    checks++;
    if (draw_en !== 1'b1) begin errors++; $display("FAIL rst_mid_launch: got %b expected 1", draw_en); end
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      step;
      if (done) got = 1;
    end
    checks++;
    if (got != 1) begin errors++; $display("FAIL rst_mid_done_timeout: got %0d expected 1", got); end
    step;
  endtask

  task automatic test_back_to_back;
    int got;
    eng_len = 1;
    pulse_start(8'h7F, 8'h3F, 4'd15, 16'h0FFF);
    checks++;
    if (draw_start_pix !== 11'h7FF) begin errors++; $display("FAIL b2b_wrap_pix: got %h expected 7ff", draw_start_pix); end
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      step;
      if (done) got = 1;
    end
    checks++;
    if (got != 1) begin errors++; $display("FAIL b2b_done_timeout: got %0d expected 1", got); end
    step;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", ready); end
    pulse_start(8'h00, 8'h00, 4'd1, 16'h0000);
    checks++;
    if ({draw_start_pix, draw_nibbles, draw_I} !== {11'h000, 4'd1, 16'h0000}) begin
      errors++; $display("FAIL b2b_operands: got %h expected %h", {draw_start_pix, draw_nibbles, draw_I}, {11'h000, 4'd1, 16'h0000});
    end
    step;
    checks++;
    if (draw_en !== 1'b1) begin errors++; $display("FAIL b2b_launch: got %b expected 1", draw_en); end
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      step;
      if (done) got = 1;
    end
    checks++;
    if (got != 1) begin errors++; $display("FAIL b2b_done2_timeout: got %0d expected 1", got); end
    step;
  endtask

  task automatic test_vsync;
    eng_len = 2;
    vs_i = 1'b1;
    step; step;
    pulse_start(8'h45, 8'h23, 4'd5, 16'h0300);
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (draw_en !== 1'b0) begin errors++; $display("FAIL vsync_early_t%0d: got %b expected 0", k, draw_en); end
      vs_i = (k < 5);
      step;
    end
    checks++;
    if (draw_en !== 1'b1) begin errors++; $display("FAIL vsync_launch: got %b expected 1", draw_en); end
  endtask

  initial begin
    test_reset;
`ifdef DRAW_VSYNC_WAIT_EN
    test_vsync;
`else
    test_basic;
    test_collision(4);
    test_collision(7);
    test_busy_hold;
    test_n_zero;
    test_reset_mid_run;
    test_back_to_back;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
